fsm_transition_monitor: RTL and testbench
=========================================

FSM_TRANSITION_MONITOR -- requirements
Module: fsm_transition_monitor

Interface
REQ-001 Parameter STATE_W, default 4, width of the observed state bus; the state space is NS = 2^STATE_W.
REQ-002 Parameter CNT_W, default 16, width of the saturating counters.
REQ-003 clk  input  1  sole clock; all logic samples on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-005 state  input  STATE_W  observed FSM state.
REQ-006 state_vld  input  1  qualifies state on the current cycle.
REQ-007 cfg_we  input  1  write strobe for the legal-successor table.
REQ-008 cfg_addr  input  STATE_W  source state whose table row is written.
REQ-009 cfg_succ  input  NS  legal-successor bitmap; bit j=1 makes cfg_addr->j legal.
REQ-010 clr  input  1  synchronous clear of error status and counters.
REQ-011 err_pulse  output  1  one-cycle flag for an illegal transition.
REQ-012 err_sticky  output  1  set on the first violation; held until clr or reset.
REQ-013 err_from, err_to  output  STATE_W each  source and destination of the first captured violation.
REQ-014 err_cnt  output  CNT_W  saturating count of violations.
REQ-015 trans_cnt  output  CNT_W  saturating count of checked transitions.
REQ-016 cov_state, cov_full  output  NS, 1  visited-state bitmap and all-visited flag (present only per REQ-031).

Function
REQ-017 The table shall be NS rows of NS bits; a cfg_we cycle writes row cfg_addr with cfg_succ, effective on the next cycle.
REQ-018 Register prev/prev_vld: on state_vld=1, prev<=state and prev_vld<=1; on state_vld=0, prev_vld<=0 (only back-to-back samples are checked).
REQ-019 A check occurs on a cycle with state_vld=1 and prev_vld=1; it is legal iff table[prev][state]=1, and self-loops need their own bit.
REQ-020 Each check increments trans_cnt; each illegal check increments err_cnt; both saturate at 2^CNT_W-1.
REQ-021 err_pulse shall be registered and assert exactly one cycle after the offending sample (latency 1).
REQ-022 On a violation with err_sticky=0, err_from<=prev, err_to<=state, err_sticky<=1; later violations do not change err_from/err_to.
REQ-023 When cfg_we writes row prev in the same cycle as a check, the check shall use the old row contents.
REQ-024 clr=1 zeroes err_cnt, trans_cnt, err_sticky, err_from, err_to and cov_state; clr has priority over a simultaneous check update, while err_pulse still reports that check.
REQ-025 clr shall not alter the table or prev/prev_vld.

Reset
REQ-026 When rst=0 at posedge clk, all outputs, counters and prev_vld shall go to 0 and every table bit to 1 (permissive).
REQ-027 cfg_we, clr and state_vld are ignored while rst=0.
REQ-028 A reset mid-sequence shall leave the first valid sample after reset unchecked, because prev_vld=0.

Configuration
REQ-029 Macro FSM_MON_COVER_EN controls state-visit coverage.
REQ-030 With FSM_MON_COVER_EN defined, each state_vld sample sets cov_state[state], and cov_full = AND of all cov_state bits.
REQ-031 Without FSM_MON_COVER_EN, cov_state and cov_full shall be absent from the port list and no coverage storage shall be built.

Verification
REQ-032 Scenario A: STATE_W=4, table holding only 0->1, 1->{2,4}, 2->3, 3->{1,5}, 4->5, 5->{1,6}, 6->7, 7->{0,8}, 8->{2,4,9,14}, 9->0, 14->0; drive 0,1,2,3,5,6,7,8,9,0 back-to-back -> err_cnt=0, trans_cnt=9, err_pulse never asserts.
REQ-033 Scenario B: same table, drive 2 then 5 -> err_pulse=1 one cycle later, err_sticky=1, err_from=2, err_to=5, err_cnt=1; then drive 9 then 3 -> err_cnt=2, err_from/err_to stay 2/5.
REQ-034 Scenario C: drive 0, then state_vld=0 for one cycle, then 5 -> no check, err_cnt=0, trans_cnt=0.
REQ-035 Scenario D: CNT_W=2, drive 6 illegal transitions -> err_cnt=3 (saturated); assert clr together with a 7th violation -> err_cnt=0, err_sticky=0, err_pulse=1.
REQ-036 Scenario E: write row 3 with 0x0001 in the same cycle as check 3->5 -> the check passes on the old row; the next 3->5 check flags a violation.
REQ-037 Scenario F (FSM_MON_COVER_EN): visit states 0..15 -> cov_state=0xFFFF and cov_full=1; then rst=0 for one cycle -> all outputs 0.

Source files
------------

// File: rtl/fsm_transition_monitor_if.sv
// fsm_transition_monitor_if: observed-state, config and status bundle.
// cov_state/cov_full exist only when FSM_MON_COVER_EN is defined.
interface fsm_transition_monitor_if #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 16
);
    localparam int NS = 1 << STATE_W;

    logic [STATE_W-1:0] state;
    logic               state_vld;
    logic               cfg_we;
    logic [STATE_W-1:0] cfg_addr;
    logic [NS-1:0]      cfg_succ;
    logic               clr;

    logic               err_pulse;
    logic               err_sticky;
    logic [STATE_W-1:0] err_from;
    logic [STATE_W-1:0] err_to;
    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W-1:0]   trans_cnt;
`ifdef FSM_MON_COVER_EN
    logic [NS-1:0]      cov_state;
    logic               cov_full;
`endif

    modport master (
        output state, state_vld, cfg_we, cfg_addr, cfg_succ, clr,
        input  err_pulse, err_sticky, err_from, err_to,
        input  err_cnt, trans_cnt
`ifdef FSM_MON_COVER_EN
        , input cov_state, cov_full
`endif
    );

    modport slave (
        input  state, state_vld, cfg_we, cfg_addr, cfg_succ, clr,
        output err_pulse, err_sticky, err_from, err_to,
        output err_cnt, trans_cnt
`ifdef FSM_MON_COVER_EN
        , output cov_state, cov_full
`endif
    );
endinterface

// File: rtl/fsm_transition_monitor.sv
// fsm_transition_monitor: checks observed FSM steps against a legal-successor table.
// Optional state-visit coverage is built only with FSM_MON_COVER_EN.
module fsm_transition_monitor #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 16
) (
    input logic                   clk,
    input logic                   rst,
    fsm_transition_monitor_if.slave mon
);
    localparam int NS = 1 << STATE_W;

    logic [NS-1:0]      succ_tbl [NS];
    logic [STATE_W-1:0] prev_q;
    logic               prev_vld_q;

    logic               err_pulse_q;
    logic               err_sticky_q;
    logic [STATE_W-1:0] err_from_q;
    logic [STATE_W-1:0] err_to_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   trans_cnt_q;

    logic check;
    logic legal;
    logic viol;

    // Table read uses the registered row, so a same-cycle write sees old contents.
    always_comb begin
        check = mon.state_vld && prev_vld_q;
        legal = succ_tbl[prev_q][mon.state];
        viol  = check && !legal;
    end

    // Legal-successor table: permissive after reset, row writes via cfg_we.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin
                succ_tbl[i] <= '1;
            end
        end else if (mon.cfg_we) begin
            succ_tbl[mon.cfg_addr] <= mon.cfg_succ;
        end
    end

    // Previous-sample tracking; a gap in state_vld breaks the chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_vld_q <= mon.state_vld;
            if (mon.state_vld) begin
                prev_q <= mon.state;
            end
        end
    end

    // Violation status and saturating counters; clr wins over updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_from_q   <= '0;
            err_to_q     <= '0;
            err_cnt_q    <= '0;
            trans_cnt_q  <= '0;
        end else begin
            err_pulse_q <= viol;
            if (mon.clr) begin
                err_sticky_q <= 1'b0;
                err_from_q   <= '0;
                err_to_q     <= '0;
                err_cnt_q    <= '0;
                trans_cnt_q  <= '0;
            end else begin
                if (check && trans_cnt_q != '1) begin
                    trans_cnt_q <= trans_cnt_q + 1'b1;
                end
                if (viol && err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
                if (viol && !err_sticky_q) begin
                    err_sticky_q <= 1'b1;
                    err_from_q   <= prev_q;
                    err_to_q     <= mon.state;
                end
            end
        end
    end

    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_sticky = err_sticky_q;
    assign mon.err_from   = err_from_q;
    assign mon.err_to     = err_to_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.trans_cnt  = trans_cnt_q;

`ifdef FSM_MON_COVER_EN
    logic [NS-1:0] cov_q;

    // Visited-state bitmap, cleared by clr or reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cov_q <= '0;
        end else if (mon.clr) begin
            cov_q <= '0;
        end else if (mon.state_vld) begin
            cov_q[mon.state] <= 1'b1;
        end
    end

    assign mon.cov_state = cov_q;
    assign mon.cov_full  = &cov_q;
`endif
endmodule

// File: tb/tb_fsm_transition_monitor.sv
// tb_fsm_transition_monitor: directed checks of the transition monitor.
// Two instances share stimulus: CNT_W=16 (a) and CNT_W=2 (b) for saturation.
module tb_fsm_transition_monitor;
    logic clk;
    logic rst;

    logic [3:0]  st;
    logic        vld;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] succ;
    logic        clr;

    int n_tests;
    int n_fail;

    fsm_transition_monitor_if #(.STATE_W(4), .CNT_W(16)) bus_a ();
    fsm_transition_monitor_if #(.STATE_W(4), .CNT_W(2))  bus_b ();

    assign bus_a.state     = st;
    assign bus_a.state_vld = vld;
    assign bus_a.cfg_we    = we;
    assign bus_a.cfg_addr  = addr;
    assign bus_a.cfg_succ  = succ;
    assign bus_a.clr       = clr;

    assign bus_b.state     = st;
    assign bus_b.state_vld = vld;
    assign bus_b.cfg_we    = we;
    assign bus_b.cfg_addr  = addr;
    assign bus_b.cfg_succ  = succ;
    assign bus_b.clr       = clr;

    fsm_transition_monitor #(.STATE_W(4), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .mon (bus_a.slave)
    );

    fsm_transition_monitor #(.STATE_W(4), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .mon (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs are set before, outputs are settled at the next negedge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] s);
        vld  = v;
        st   = s;
        we   = 1'b0;
        clr  = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        vld = 1'b0;
        we  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    logic [15:0] rows [16];
    logic [3:0]  seq_a [10];
    int          pulses;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b0;
        st   = '0;
        vld  = 1'b1;
        we   = 1'b1;
        addr = 4'd0;
        succ = 16'h0000;
        clr  = 1'b1;
        tick();
        tick();

        chk("rst_err_cnt",   bus_a.err_cnt, 0);
        chk("rst_trans_cnt", bus_a.trans_cnt, 0);
        chk("rst_sticky",    bus_a.err_sticky, 0);
        chk("rst_pulse",     bus_a.err_pulse, 0);
        chk("rst_from_to",   {bus_a.err_from, bus_a.err_to}, 0);

        rst = 1'b1;
        vld = 1'b0;
        we  = 1'b0;
        clr = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) rows[i] = 16'h0000;
        rows[0]  = 16'h0002;
        rows[1]  = 16'h0014;
        rows[2]  = 16'h0008;
        rows[3]  = 16'h0022;
        rows[4]  = 16'h0020;
        rows[5]  = 16'h0042;
        rows[6]  = 16'h0080;
        rows[7]  = 16'h0101;
        rows[8]  = 16'h4214;
        rows[9]  = 16'h0001;
        rows[14] = 16'h0001;
        for (int i = 0; i < 16; i++) begin
            vld  = 1'b0;
            we   = 1'b1;
            addr = 4'(i);
            succ = rows[i];
            tick();
        end
        we = 1'b0;

        // Scenario A: legal walk
        seq_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, seq_a[i]);
            if (bus_a.err_pulse) pulses++;
        end
        drive(1'b0, 4'd0);
        if (bus_a.err_pulse) pulses++;
        chk("A_pulses",    pulses, 0);
        chk("A_err_cnt",   bus_a.err_cnt, 0);
        chk("A_trans_cnt", bus_a.trans_cnt, 9);
        chk("A_trans_sat", bus_b.trans_cnt, 3);

        // Scenario B: first violation captured, later one only counted
        do_clr();
        chk("B_clr_trans", bus_a.trans_cnt, 0);
        drive(1'b1, 4'd2);
        chk("B_no_pulse_early", bus_a.err_pulse, 0);
        drive(1'b1, 4'd5);
        chk("B_pulse",   bus_a.err_pulse, 1);
        chk("B_sticky",  bus_a.err_sticky, 1);
        chk("B_from",    bus_a.err_from, 2);
        chk("B_to",      bus_a.err_to, 5);
        chk("B_err_cnt", bus_a.err_cnt, 1);
        drive(1'b0, 4'd0);
        chk("B_pulse_1cyc", bus_a.err_pulse, 0);
        drive(1'b1, 4'd9);
        drive(1'b1, 4'd3);
        chk("B_err_cnt2", bus_a.err_cnt, 2);
        chk("B_from_held", {bus_a.err_from, bus_a.err_to}, 8'h25);
        chk("B_trans",   bus_a.trans_cnt, 2);
        drive(1'b0, 4'd0);

        // Scenario C: gap in state_vld suppresses the check
        do_clr();
        drive(1'b1, 4'd0);
        drive(1'b0, 4'd0);
        drive(1'b1, 4'd5);
        chk("C_pulse",   bus_a.err_pulse, 0);
        chk("C_err_cnt", bus_a.err_cnt, 0);
        chk("C_trans",   bus_a.trans_cnt, 0);
        drive(1'b0, 4'd0);

        // Scenario D: saturation on the CNT_W=2 instance, clr vs violation
        do_clr();
        for (int i = 0; i < 7; i++) drive(1'b1, 4'd10);
        chk("D_err_sat_b",  bus_b.err_cnt, 3);
        chk("D_err_cnt_a",  bus_a.err_cnt, 6);
        chk("D_from_to",    {bus_a.err_from, bus_a.err_to}, 8'hAA);
        vld = 1'b1;
        st  = 4'd10;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("D_clr_err_b",  bus_b.err_cnt, 0);
        chk("D_clr_sticky", bus_b.err_sticky, 0);
        chk("D_clr_pulse",  bus_b.err_pulse, 1);
        chk("D_clr_trans",  bus_a.trans_cnt, 0);
        chk("D_clr_from",   {bus_a.err_from, bus_a.err_to}, 0);
        drive(1'b0, 4'd0);

        // Scenario E: row rewrite in the same cycle as a check uses old row
        drive(1'b1, 4'd3);
        vld  = 1'b1;
        st   = 4'd5;
        we   = 1'b1;
        addr = 4'd3;
        succ = 16'h0001;
        tick();
        we = 1'b0;
        chk("E_old_row", bus_a.err_pulse, 0);
        chk("E_err0",    bus_a.err_cnt, 0);
        drive(1'b0, 4'd0);
        drive(1'b1, 4'd3);
        drive(1'b1, 4'd5);
        chk("E_new_row", bus_a.err_pulse, 1);
        chk("E_err1",    bus_a.err_cnt, 1);
        chk("E_from_to", {bus_a.err_from, bus_a.err_to}, 8'h35);

        // Reset mid-sequence: inputs ignored, table permissive again
        drive(1'b1, 4'd10);
        rst = 1'b0;
        vld = 1'b1;
        st  = 4'd10;
        we  = 1'b1;
        clr = 1'b0;
        tick();
        we = 1'b0;
        chk("R_err_cnt", bus_a.err_cnt, 0);
        chk("R_sticky",  bus_a.err_sticky, 0);
        chk("R_pulse",   bus_a.err_pulse, 0);
        rst = 1'b1;
        drive(1'b1, 4'd10);
        chk("R_first_unchecked", bus_a.trans_cnt, 0);
        drive(1'b1, 4'd10);
        chk("R_permissive_pulse", bus_a.err_pulse, 0);
        chk("R_permissive_trans", bus_a.trans_cnt, 1);
        drive(1'b0, 4'd0);

`ifdef FSM_MON_COVER_EN
        // Scenario F: visit every state
        do_clr();
        chk("F_cov_clr", bus_a.cov_state, 0);
        for (int i = 0; i < 15; i++) drive(1'b1, 4'(i));
        chk("F_not_full", bus_a.cov_full, 0);
        chk("F_cov_15",   bus_a.cov_state, 32'h7FFF);
        drive(1'b1, 4'd15);
        chk("F_cov_all",  bus_a.cov_state, 32'hFFFF);
        chk("F_full",     bus_a.cov_full, 1);
        rst = 1'b0;
        vld = 1'b0;
        tick();
        chk("F_rst_cov",  bus_a.cov_state, 0);
        chk("F_rst_full", bus_a.cov_full, 0);
        chk("F_rst_cnt",  bus_a.trans_cnt, 0);
        rst = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
